de_pipe_reg: RTL and testbench

//   Decode->Execute pipeline register of the 5-stage RV32I core. Captures the decode

---
 rtl/rv32i_pkg.sv | 49 ++++
 rtl/pipe_field_reg.sv | 26 ++
 rtl/de_pipe_reg.sv | 149 ++++++++++++++
 tb/tb_de_pipe_reg.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and encodings for the RV32I pipeline control path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rv32i_pkg;

   // Field widths of the decode control word
   localparam int RESULT_SRC_W = 2;
   localparam int MEM_WRITE_W  = 3;
   localparam int JUMP_W       = 2;
   localparam int ALU_CTRL_W   = 3;
   localparam int PERF_CNT_W   = 32;

   // ResultSrc: which value the writeback mux selects
   localparam logic [RESULT_SRC_W-1:0] RES_ALU = 2'd0;
   localparam logic [RESULT_SRC_W-1:0] RES_MEM = 2'd1;
   localparam logic [RESULT_SRC_W-1:0] RES_PC4 = 2'd2;

   // MemWrite: store size; zero means no store, so a cleared word never writes memory
   localparam logic [MEM_WRITE_W-1:0] MEM_NONE = 3'd0;
   localparam logic [MEM_WRITE_W-1:0] MEM_SB   = 3'd1;
   localparam logic [MEM_WRITE_W-1:0] MEM_SH   = 3'd2;
   localparam logic [MEM_WRITE_W-1:0] MEM_SW   = 3'd4;

   // Jump: zero means no redirect, so a cleared word never steers the PC
   localparam logic [JUMP_W-1:0] JMP_NONE = 2'd0;
   localparam logic [JUMP_W-1:0] JMP_JAL  = 2'd1;
   localparam logic [JUMP_W-1:0] JMP_JALR = 2'd2;

   // Control word carried from decode into execute
   typedef struct packed {
      logic                    reg_write;
      logic [RESULT_SRC_W-1:0] result_src;
      logic [MEM_WRITE_W-1:0]  mem_write;
      logic [JUMP_W-1:0]       jump;
      logic                    branch;
      logic [ALU_CTRL_W-1:0]   alu_control;
      logic                    alu_src;
      logic                    valid;
   } ctrl_e_t;

   // The all-zero control word is the bubble: no writes, no redirect, not valid
   localparam ctrl_e_t CTRL_BUBBLE = '0;

   // Saturating increment for the performance counters
   function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
      return (v == {PERF_CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// pipe_field_reg: one pipeline-register field with hold and synchronous clear.
// Latency: 1 clk from d to q.
// Backpressure: en=0 holds q; clr forces q to zero and overrides en.
module pipe_field_reg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Clear beats enable so a bubble can be forced even while the stage is held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/de_pipe_reg.sv
// de_pipe_reg: decode->execute pipeline register with valid bit and bubble insertion.
// Latency: 1 clk; every output is a flop, no input-to-output combinational path.
// Backpressure: FlushE_i (or invalid load) loads a bubble, StallE_i holds; DE_PERF_CNT_EN adds bubble/stall counters.
module de_pipe_reg
   import rv32i_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    StallE_i,
   input  logic                    FlushE_i,
   input  logic                    ValidD_i,
   input  logic                    RegWriteD_i,
   input  logic [RESULT_SRC_W-1:0] ResultSrcD_i,
   input  logic [MEM_WRITE_W-1:0]  MemWriteD_i,
   input  logic [JUMP_W-1:0]       JumpD_i,
   input  logic                    BranchD_i,
   input  logic [ALU_CTRL_W-1:0]   ALUControlD_i,
   input  logic                    ALUSrcD_i,
   input  logic [XLEN-1:0]         RD1D_i,
   input  logic [XLEN-1:0]         RD2D_i,
   input  logic [XLEN-1:0]         ImmExtD_i,
   input  logic [REG_AW-1:0]       Rs1D_i,
   input  logic [REG_AW-1:0]       Rs2D_i,
   input  logic [REG_AW-1:0]       RdD_i,
   input  logic [XLEN-1:0]         PCD_i,
   input  logic [XLEN-1:0]         PCPlus4D_i,
   output logic                    ValidE_o,
   output logic                    RegWriteE_o,
   output logic [RESULT_SRC_W-1:0] ResultSrcE_o,
   output logic [MEM_WRITE_W-1:0]  MemWriteE_o,
   output logic [JUMP_W-1:0]       JumpE_o,
   output logic                    BranchE_o,
   output logic [ALU_CTRL_W-1:0]   ALUControlE_o,
   output logic                    ALUSrcE_o,
   output logic [XLEN-1:0]         RD1E_o,
   output logic [XLEN-1:0]         RD2E_o,
   output logic [XLEN-1:0]         ImmExtE_o,
   output logic [REG_AW-1:0]       Rs1E_o,
   output logic [REG_AW-1:0]       Rs2E_o,
   output logic [REG_AW-1:0]       RdE_o,
   output logic [XLEN-1:0]         PCE_o,
   output logic [XLEN-1:0]         PCPlus4E_o,
   output logic [PERF_CNT_W-1:0]   BubbleCntE_o,
   output logic [PERF_CNT_W-1:0]   StallCntE_o
);

   logic    load_en;
   logic    bubble_ld;
   ctrl_e_t ctrl_d;
   ctrl_e_t ctrl_q;

   // Flush always bubbles; an invalid slot only bubbles when the stage actually loads,
   // so a stall with ValidD_i low still holds the current entry untouched.
   assign load_en   = ~StallE_i;
   assign bubble_ld = FlushE_i | (~StallE_i & ~ValidD_i);

   // Pack decode control fields into the control word
   always_comb begin
      ctrl_d             = CTRL_BUBBLE;
      ctrl_d.reg_write   = RegWriteD_i;
      ctrl_d.result_src  = ResultSrcD_i;
      ctrl_d.mem_write   = MemWriteD_i;
      ctrl_d.jump        = JumpD_i;
      ctrl_d.branch      = BranchD_i;
      ctrl_d.alu_control = ALUControlD_i;
      ctrl_d.alu_src     = ALUSrcD_i;
      ctrl_d.valid       = ValidD_i;
   end

   pipe_field_reg #(.W($bits(ctrl_e_t))) u_ctrl (
      .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bubble_ld), .d(ctrl_d), .q(ctrl_q)
   );

   pipe_field_reg #(.W(XLEN)) u_rd1 (
      .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bubble_ld), .d(RD1D_i), .q(RD1E_o)
   );

   pipe_field_reg #(.W(XLEN)) u_rd2 (
      .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bubble_ld), .d(RD2D_i), .q(RD2E_o)
   );

   pipe_field_reg #(.W(XLEN)) u_imm (
      .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bubble_ld), .d(ImmExtD_i), .q(ImmExtE_o)
   );

   pipe_field_reg #(.W(REG_AW)) u_rs1 (
      .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bubble_ld), .d(Rs1D_i), .q(Rs1E_o)
   );

   pipe_field_reg #(.W(REG_AW)) u_rs2 (
      .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bubble_ld), .d(Rs2D_i), .q(Rs2E_o)
   );

   pipe_field_reg #(.W(REG_AW)) u_rd (
      .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bubble_ld), .d(RdD_i), .q(RdE_o)
   );

   pipe_field_reg #(.W(XLEN)) u_pc (
      .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bubble_ld), .d(PCD_i), .q(PCE_o)
   );

   pipe_field_reg #(.W(XLEN)) u_pc4 (
      .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bubble_ld), .d(PCPlus4D_i), .q(PCPlus4E_o)
   );

   // Unpack the registered control word onto the execute-side ports
   assign ValidE_o      = ctrl_q.valid;
   assign RegWriteE_o   = ctrl_q.reg_write;
   assign ResultSrcE_o  = ctrl_q.result_src;
   assign MemWriteE_o   = ctrl_q.mem_write;
   assign JumpE_o       = ctrl_q.jump;
   assign BranchE_o     = ctrl_q.branch;
   assign ALUControlE_o = ctrl_q.alu_control;
   assign ALUSrcE_o     = ctrl_q.alu_src;

`ifdef DE_PERF_CNT_EN
   logic                  stall_hold;
   logic [PERF_CNT_W-1:0] bubble_cnt_q;
   logic [PERF_CNT_W-1:0] stall_cnt_q;

   // A flush takes priority over a stall, so it does not count as a stall cycle
   assign stall_hold = StallE_i & ~FlushE_i;

   // Saturating counts of bubbles loaded and stall cycles taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         if (bubble_ld) begin
            bubble_cnt_q <= sat_inc(bubble_cnt_q);
         end
         if (stall_hold) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
         end
      end
   end

   assign BubbleCntE_o = bubble_cnt_q;
   assign StallCntE_o  = stall_cnt_q;
`else
   assign BubbleCntE_o = '0;
   assign StallCntE_o  = '0;
`endif

endmodule

// File: tb/tb_de_pipe_reg.sv
// tb_de_pipe_reg: randomized self-checking bench for the decode->execute register.
// Latency: expected E contents follow the D inputs one clk behind.
// Backpressure: drives stall/flush/valid patterns and checks hold and bubble behaviour.
module tb_de_pipe_reg;
   import rv32i_pkg::*;

   // Whole E-side view as one record: control fields, then data fields
   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic [1:0]  result_src;
      logic [2:0]  mem_write;
      logic [1:0]  jump;
      logic        branch;
      logic [2:0]  alu_control;
      logic        alu_src;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] pc4;
   } slot_t;

   logic  clk   = 1'b0;
   logic  rst_n = 1'b0;
   logic  stall = 1'b0;
   logic  flush = 1'b0;
   slot_t d     = '0;
   slot_t obs;
   slot_t exp_e = '0;
   logic [31:0] bub_cnt, stall_cnt;
   logic [31:0] exp_bub   = '0;
   logic [31:0] exp_stall = '0;
   int n_vec = 0;
   int n_err = 0;

   logic        v_e, rw_e, br_e, as_e;
   logic [1:0]  rs_e, j_e;
   logic [2:0]  mw_e, ac_e;
   logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
   logic [4:0]  rs1_e, rs2_e, rdd_e;

   always #10 clk = ~clk;

   de_pipe_reg dut (
      .clk(clk), .rst_n(rst_n), .StallE_i(stall), .FlushE_i(flush), .ValidD_i(d.valid),
      .RegWriteD_i(d.reg_write), .ResultSrcD_i(d.result_src), .MemWriteD_i(d.mem_write),
      .JumpD_i(d.jump), .BranchD_i(d.branch), .ALUControlD_i(d.alu_control),
      .ALUSrcD_i(d.alu_src), .RD1D_i(d.rd1), .RD2D_i(d.rd2), .ImmExtD_i(d.imm),
      .Rs1D_i(d.rs1), .Rs2D_i(d.rs2), .RdD_i(d.rd), .PCD_i(d.pc), .PCPlus4D_i(d.pc4),
      .ValidE_o(v_e), .RegWriteE_o(rw_e), .ResultSrcE_o(rs_e), .MemWriteE_o(mw_e),
      .JumpE_o(j_e), .BranchE_o(br_e), .ALUControlE_o(ac_e), .ALUSrcE_o(as_e),
      .RD1E_o(rd1_e), .RD2E_o(rd2_e), .ImmExtE_o(imm_e), .Rs1E_o(rs1_e), .Rs2E_o(rs2_e),
      .RdE_o(rdd_e), .PCE_o(pc_e), .PCPlus4E_o(pc4_e),
      .BubbleCntE_o(bub_cnt), .StallCntE_o(stall_cnt)
   );

   assign obs = {v_e, rw_e, rs_e, mw_e, j_e, br_e, ac_e, as_e,
                 rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rdd_e, pc_e, pc4_e};

   task automatic rand_slot(output slot_t s);
      logic [191:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      s = slot_t'(r[$bits(slot_t)-1:0]);
      s.valid = ($urandom_range(0, 9) < 8);
   endtask

   // Reference model: one rising edge, then move to the falling edge for sampling.
   // Rules: flush -> bubble; else stall -> hold; else invalid -> bubble; else copy.
   task automatic clk_step();
      @(posedge clk);
      if (rst_n) begin
         if (flush || (!stall && !d.valid)) begin
            exp_e = '0;
`ifdef DE_PERF_CNT_EN
            if (exp_bub != 32'hFFFF_FFFF) exp_bub = exp_bub + 1;
`endif
         end else if (stall) begin
`ifdef DE_PERF_CNT_EN
            if (exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
`endif
         end else begin
            exp_e = d;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      d = '1; stall = 1'b1; flush = 1'b1; rst_n = 1'b0;
      #1;
      n_vec++;
      if (obs !== '0) begin n_err++; $display("FAIL reset_initial: got %h expected 0", obs); end
      n_vec++;
      if ({bub_cnt, stall_cnt} !== 64'd0) begin
         n_err++; $display("FAIL reset_initial_cnt: got %h/%h expected 0", bub_cnt, stall_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
      rand_slot(d); d.valid = 1'b1;
      clk_step();
      n_vec++;
      if (obs !== exp_e) begin n_err++; $display("FAIL load_before_reset: got %h expected %h", obs, exp_e); end
      // Pulse reset between edges with every input high
      d = '1; stall = 1'b1; flush = 1'b1;
      #2 rst_n = 1'b0;
      exp_e = '0; exp_bub = '0; exp_stall = '0;
      #1;
      n_vec++;
      if (obs !== '0) begin n_err++; $display("FAIL reset_async: got %h expected 0", obs); end
      #1 rst_n = 1'b1;
      #1;
      n_vec++;
      if (obs !== '0) begin n_err++; $display("FAIL reset_release_hold: got %h expected 0", obs); end
      n_vec++;
      if ({bub_cnt, stall_cnt} !== 64'd0) begin
         n_err++; $display("FAIL reset_release_cnt: got %h/%h expected 0", bub_cnt, stall_cnt);
      end
      clk_step();
      n_vec++;
      if (obs !== exp_e || bub_cnt !== exp_bub) begin
         n_err++; $display("FAIL reset_first_clk: got %h/%h expected %h/%h", obs, bub_cnt, exp_e, exp_bub);
      end
      stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_pass_through();
      d = '0; d.rd1 = 32'h1234_5678; d.rd = 5'd10; d.reg_write = 1'b1; d.valid = 1'b1;
      stall = 1'b0; flush = 1'b0;
      clk_step();
      n_vec++;
      if (rd1_e !== 32'h1234_5678 || rdd_e !== 5'd10 || rw_e !== 1'b1 || v_e !== 1'b1) begin
         n_err++; $display("FAIL pass_fields: got rd1=%h rd=%0d rw=%b v=%b expected 12345678/10/1/1", rd1_e, rdd_e, rw_e, v_e);
      end
      n_vec++;
      if (obs !== exp_e) begin n_err++; $display("FAIL pass_all: got %h expected %h", obs, exp_e); end
   endtask

   task automatic test_stall();
      slot_t held;
      rand_slot(d); d.valid = 1'b1; stall = 1'b0; flush = 1'b0;
      clk_step();
      held = d;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_slot(d);
         clk_step();
         n_vec++;
         if (obs !== held) begin n_err++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs, held); end
      end
      n_vec++;
      if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
      // An invalid slot arriving during a stall must not disturb the held entry
      d.valid = 1'b0;
      clk_step();
      n_vec++;
      if (obs !== held) begin n_err++; $display("FAIL stall_invalid_hold: got %h expected %h", obs, held); end
      stall = 1'b0;
   endtask

   task automatic test_flush();
      rand_slot(d); d.valid = 1'b1; d.mem_write = 3'b010; d.jump = 2'b01;
      stall = 1'b0; flush = 1'b1;
      clk_step();
      n_vec++;
      if (mw_e !== 3'd0 || j_e !== 2'd0 || v_e !== 1'b0) begin
         n_err++; $display("FAIL flush_ctrl: got mw=%b j=%b v=%b expected 0/0/0", mw_e, j_e, v_e);
      end
      n_vec++;
      if (obs !== exp_e) begin n_err++; $display("FAIL flush_all: got %h expected %h", obs, exp_e); end
      n_vec++;
      if (bub_cnt !== exp_bub) begin n_err++; $display("FAIL flush_cnt: got %0d expected %0d", bub_cnt, exp_bub); end
      flush = 1'b0;
   endtask

   task automatic test_stall_flush();
      rand_slot(d); d.valid = 1'b1; stall = 1'b0; flush = 1'b0;
      clk_step();
      rand_slot(d); d.valid = 1'b1; stall = 1'b1; flush = 1'b1;
      clk_step();
      n_vec++;
      if (obs !== '0) begin n_err++; $display("FAIL stall_flush_bubble: got %h expected 0", obs); end
      n_vec++;
      if (stall_cnt !== exp_stall || bub_cnt !== exp_bub) begin
         n_err++; $display("FAIL stall_flush_cnt: got %0d/%0d expected %0d/%0d", stall_cnt, bub_cnt, exp_stall, exp_bub);
      end
      stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_invalid();
      rand_slot(d); d.valid = 1'b0; d.reg_write = 1'b1; stall = 1'b0; flush = 1'b0;
      clk_step();
      n_vec++;
      if (rw_e !== 1'b0 || v_e !== 1'b0) begin
         n_err++; $display("FAIL invalid_gate: got rw=%b v=%b expected 0/0", rw_e, v_e);
      end
      n_vec++;
      if (obs !== exp_e || bub_cnt !== exp_bub) begin
         n_err++; $display("FAIL invalid_all: got %h/%0d expected %h/%0d", obs, bub_cnt, exp_e, exp_bub);
      end
   endtask

   task automatic test_reset_mid_stall();
      rand_slot(d); d.valid = 1'b1; stall = 1'b0; flush = 1'b0;
      clk_step();
      stall = 1'b1;
      clk_step();
      flush = 1'b1;
      #3 rst_n = 1'b0;
      exp_e = '0; exp_bub = '0; exp_stall = '0;
      #1;
      n_vec++;
      if (obs !== '0 || bub_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
         n_err++; $display("FAIL reset_mid_stall: got %h/%0d/%0d expected 0", obs, bub_cnt, stall_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
      rand_slot(d); d.valid = 1'b1;
      clk_step();
      n_vec++;
      if (obs !== exp_e || bub_cnt !== exp_bub || stall_cnt !== exp_stall) begin
         n_err++; $display("FAIL after_reset_load: got %h/%0d/%0d expected %h/%0d/%0d", obs, bub_cnt, stall_cnt, exp_e, exp_bub, exp_stall);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rand_slot(d);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 9) == 0);
         clk_step();
         n_vec++;
         if (obs !== exp_e) begin n_err++; $display("FAIL random_obs[%0d]: got %h expected %h", i, obs, exp_e); end
         n_vec++;
         if (bub_cnt !== exp_bub || stall_cnt !== exp_stall) begin
            n_err++; $display("FAIL random_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, bub_cnt, stall_cnt, exp_bub, exp_stall);
         end
      end
      stall = 1'b0; flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_stall();
      test_flush();
      test_stall_flush();
      test_invalid();
      test_reset_mid_stall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
